fpnew_share_ctrl: RTL and testbench

Shares one FPU instance (fpnew_top) between NumReq independent requesters, for example cores or vector lanes. A round-robin arbiter with grant lock issues requests into the FPU. A slot table stores each request's owner and original tag, and the FPU carries only the slot index as its tag. Because the FPU's operation groups can complete out of order, responses are routed back to the owning requester by slot index.

---
 rtl/fpnew_share_pkg.sv | 26 ++
 rtl/fpnew_share_rr_arb.sv | 43 ++++
 rtl/fpnew_share_ctrl.sv | 148 ++++++++++++++
 tb/tb_fpnew_share_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_share_pkg.sv
// Shared helpers for the FPU sharing controller: slot-vector bit scans.
package fpnew_share_pkg;

  // Upper bound on NumSlots handled by the bit-scan helpers.
  localparam int unsigned MaxSlots = 32;

  // Index of the lowest set bit; MaxSlots when the vector is empty.
  function automatic int unsigned lzc_lowest(input logic [MaxSlots-1:0] v);
    int unsigned idx;
    idx = MaxSlots;
    for (int unsigned i = MaxSlots; i > 0; i--) begin
      if (v[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

  function automatic int unsigned popcount(input logic [MaxSlots-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MaxSlots; i++) begin
      if (v[i]) cnt = cnt + 1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fpnew_share_rr_arb.sv
// Round-robin grant over NumReq requesters, searching upward from ptr with wrap.
// A held lock forces the grant to lock_idx so a stalled issue stays stable.
module fpnew_share_rr_arb
  import fpnew_share_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   ptr,
  input  logic              lock_valid,
  input  logic [IdxW-1:0]   lock_idx,
  output logic              any,
  output logic [IdxW-1:0]   idx,
  output logic [NumReq-1:0] onehot
);

  int unsigned cand;
  logic [IdxW-1:0] cidx;

  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = 0;
    cidx = '0;
    if (lock_valid) begin
      any = valid[lock_idx];
      idx = lock_idx;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        cand = (32'(ptr) + i) % NumReq;
        cidx = IdxW'(cand);
        if (!any && valid[cidx]) begin
          any = 1'b1;
          idx = cidx;
        end
      end
    end
    onehot = '0;
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/fpnew_share_ctrl.sv
// Shares one FPU between NumReq requesters: round-robin issue with grant lock,
// slot table mapping FPU-side slot tags back to owner and original tag.
module fpnew_share_ctrl
  import fpnew_share_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned NumSlots = 4,
  parameter type PayloadType = logic,
  parameter type RspType     = logic,
  parameter type TagType     = logic,
  localparam int unsigned SlotIdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1,
  localparam int unsigned CntW     = $clog2(NumSlots + 1),
  localparam int unsigned ReqIdxW  = $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [NumReq-1:0]   req_valid_i,
  output logic [NumReq-1:0]   req_ready_o,
  input  PayloadType          req_payload_i [NumReq],
  input  TagType              req_tag_i     [NumReq],
  output logic                fpu_valid_o,
  input  logic                fpu_ready_i,
  output PayloadType          fpu_payload_o,
  output logic [SlotIdxW-1:0] fpu_tag_o,
  input  logic                fpu_rsp_valid_i,
  output logic                fpu_rsp_ready_o,
  input  RspType              fpu_rsp_payload_i,
  input  logic [SlotIdxW-1:0] fpu_rsp_tag_i,
  output logic [NumReq-1:0]   rsp_valid_o,
  input  logic [NumReq-1:0]   rsp_ready_i,
  output RspType              rsp_payload_o,
  output TagType              rsp_tag_o,
  output logic                busy_o,
  output logic [CntW-1:0]     inflight_o
);

  // Entry type lives here because its tag field depends on TagType.
  typedef struct packed {
    logic [ReqIdxW-1:0] owner;
    TagType             tag;
  } slot_entry_t;

  logic [NumSlots-1:0] slot_valid;
  slot_entry_t         slots [NumSlots];
  logic [ReqIdxW-1:0]  rr_ptr;
  logic                lock_valid;
  logic [ReqIdxW-1:0]  lock_idx;

  logic                grant_any;
  logic [ReqIdxW-1:0]  grant_idx;
  logic [NumReq-1:0]   grant_onehot;
  logic [ReqIdxW-1:0]  rr_next;

  logic [MaxSlots-1:0] free_ext;
  logic [MaxSlots-1:0] valid_ext;
  logic                has_free;
  logic [SlotIdxW-1:0] alloc_idx;
  logic                issue_fire;

  slot_entry_t         rsp_entry;
  logic [ReqIdxW-1:0]  rsp_owner;
  logic                rsp_hit;
  logic                rsp_fire;

  fpnew_share_rr_arb #(
    .NumReq (NumReq)
  ) u_arb (
    .valid      (req_valid_i),
    .ptr        (rr_ptr),
    .lock_valid (lock_valid),
    .lock_idx   (lock_idx),
    .any        (grant_any),
    .idx        (grant_idx),
    .onehot     (grant_onehot)
  );

  // Slot allocation and occupancy come from registered state only.
  always_comb begin
    free_ext                = '0;
    free_ext[NumSlots-1:0]  = ~slot_valid;
    valid_ext               = '0;
    valid_ext[NumSlots-1:0] = slot_valid;
    has_free                = ~&slot_valid;
    alloc_idx               = SlotIdxW'(lzc_lowest(free_ext));
    inflight_o              = CntW'(popcount(valid_ext));
    busy_o                  = |slot_valid;
  end

  always_comb begin
    fpu_valid_o   = grant_any & has_free & ~flush_i;
    fpu_payload_o = req_payload_i[grant_idx];
    fpu_tag_o     = alloc_idx;
    issue_fire    = fpu_valid_o & fpu_ready_i;
    req_ready_o   = issue_fire ? grant_onehot : '0;
    rr_next       = (32'(grant_idx) == NumReq - 1) ? '0 : grant_idx + 1'b1;
  end

  // Tags beyond NumSlots read a zero valid bit, so they take the drop path.
  always_comb begin
    rsp_hit         = valid_ext[fpu_rsp_tag_i];
    rsp_entry       = slots[fpu_rsp_tag_i];
    rsp_owner       = rsp_entry.owner;
    rsp_valid_o     = '0;
    if (fpu_rsp_valid_i && rsp_hit && !flush_i) rsp_valid_o[rsp_owner] = 1'b1;
    fpu_rsp_ready_o = rsp_hit ? rsp_ready_i[rsp_owner] : 1'b1;
    rsp_fire        = fpu_rsp_valid_i & rsp_hit & rsp_ready_i[rsp_owner] & ~flush_i;
    rsp_payload_o   = fpu_rsp_payload_i;
    rsp_tag_o       = rsp_entry.tag;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_valid <= '0;
      lock_valid <= 1'b0;
      lock_idx   <= '0;
      rr_ptr     <= '0;
    end else if (flush_i) begin
      slot_valid <= '0;
      lock_valid <= 1'b0;
    end else begin
      // Issue always targets a free slot and a response a valid one, so both
      // updates can land in the same cycle without colliding.
      if (rsp_fire) slot_valid[fpu_rsp_tag_i] <= 1'b0;
      if (issue_fire) begin
        slot_valid[alloc_idx] <= 1'b1;
        rr_ptr                <= rr_next;
        lock_valid            <= 1'b0;
      end else if (fpu_valid_o) begin
        lock_valid <= 1'b1;
        lock_idx   <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue_fire) begin
      slots[alloc_idx] <= '{owner: grant_idx, tag: req_tag_i[grant_idx]};
    end
  end

  // A response addressed to an empty slot is dropped; it should never happen.
  rsp_to_valid_slot : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (fpu_rsp_valid_i && !flush_i) |-> rsp_hit
  );

endmodule

// File: tb/tb_fpnew_share_ctrl.sv
// Randomized bench for fpnew_share_ctrl: reference model of arbitration and
// slot occupancy, a fake out-of-order FPU, and a scoreboard for responses.
module tb_fpnew_share_ctrl;

  localparam int unsigned NR = 4;
  localparam int unsigned NS = 4;
  typedef logic [15:0] pay_t;
  typedef logic [15:0] res_t;
  typedef logic [7:0]  tag_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic [NR-1:0] req_valid_i;
  logic [NR-1:0] req_ready_o;
  pay_t          req_payload_i [NR];
  tag_t          req_tag_i     [NR];
  logic          fpu_valid_o;
  logic          fpu_ready_i;
  pay_t          fpu_payload_o;
  logic [1:0]    fpu_tag_o;
  logic          fpu_rsp_valid_i;
  logic          fpu_rsp_ready_o;
  res_t          fpu_rsp_payload_i;
  logic [1:0]    fpu_rsp_tag_i;
  logic [NR-1:0] rsp_valid_o;
  logic [NR-1:0] rsp_ready_i;
  res_t          rsp_payload_o;
  tag_t          rsp_tag_o;
  logic          busy_o;
  logic [2:0]    inflight_o;

  always #5 clk = ~clk;

  fpnew_share_ctrl #(
    .NumReq      (NR),
    .NumSlots    (NS),
    .PayloadType (pay_t),
    .RspType     (res_t),
    .TagType     (tag_t)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_payload_i     (req_payload_i),
    .req_tag_i         (req_tag_i),
    .fpu_valid_o       (fpu_valid_o),
    .fpu_ready_i       (fpu_ready_i),
    .fpu_payload_o     (fpu_payload_o),
    .fpu_tag_o         (fpu_tag_o),
    .fpu_rsp_valid_i   (fpu_rsp_valid_i),
    .fpu_rsp_ready_o   (fpu_rsp_ready_o),
    .fpu_rsp_payload_i (fpu_rsp_payload_i),
    .fpu_rsp_tag_i     (fpu_rsp_tag_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_payload_o     (rsp_payload_o),
    .rsp_tag_o         (rsp_tag_o),
    .busy_o            (busy_o),
    .inflight_o        (inflight_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The fake FPU's operation: any fixed bijection of the payload will do.
  function automatic res_t fpu_op(input pay_t p);
    return {p[7:0], p[15:8]} ^ 16'h3C5A;
  endfunction

  typedef struct { int req; tag_t tag; res_t res; } exp_t;
  typedef struct { int slot; res_t res; } fop_t;
  exp_t sb[$];
  fop_t fq[$];

  // Reference state: which slots are busy and who owns them, fairness pointer, lock.
  bit   m_valid [NS];
  int   m_owner [NS];
  int   m_rr;
  bit   m_lock;
  int   m_lock_idx;

  bit   r_act   [NR];
  tag_t r_tag   [NR];
  pay_t r_pay   [NR];
  tag_t tag_cnt [NR];

  bit   h_act;
  int   h_slot;
  res_t h_res;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
    m_rr   = 0;
    m_lock = 1'b0;
    fq.delete();
    sb.delete();
    h_act  = 1'b0;
  endtask

  task automatic drive_idle();
    flush_i         = 1'b0;
    req_valid_i     = '0;
    fpu_ready_i     = 1'b0;
    fpu_rsp_valid_i = 1'b0;
    fpu_rsp_tag_i   = '0;
    fpu_rsp_payload_i = '0;
    rsp_ready_i     = '0;
    for (int r = 0; r < NR; r++) begin
      req_payload_i[r] = '0;
      req_tag_i[r]     = '0;
    end
  endtask

  task automatic drive(input int cyc);
    int ret_pct;
    int k;
    for (int r = 0; r < NR; r++) begin
      if (!r_act[r] && $urandom_range(0, 99) < 40) begin
        r_act[r]   = 1'b1;
        r_tag[r]   = tag_cnt[r];
        tag_cnt[r] = tag_cnt[r] + 8'd1;
        r_pay[r]   = pay_t'($urandom);
      end
      req_valid_i[r]   = r_act[r];
      req_payload_i[r] = r_pay[r];
      req_tag_i[r]     = r_tag[r];
      rsp_ready_i[r]   = ($urandom_range(0, 99) < 75);
    end
    fpu_ready_i = ($urandom_range(0, 99) < 65);
    flush_i     = ($urandom_range(0, 99) < 2);
    // Slow-return windows let the slot table fill up.
    ret_pct = (cyc % 400 < 150) ? 8 : 55;
    if (!h_act && fq.size() > 0 && $urandom_range(0, 99) < ret_pct) begin
      k      = $urandom_range(0, fq.size() - 1);
      h_act  = 1'b1;
      h_slot = fq[k].slot;
      h_res  = fq[k].res;
    end
    fpu_rsp_valid_i   = h_act;
    fpu_rsp_tag_i     = h_act ? 2'(h_slot) : 2'($urandom_range(0, NS - 1));
    fpu_rsp_payload_i = h_act ? h_res : res_t'($urandom);
  endtask

  task automatic check_and_update();
    int g, s, cnt, t, o, c;
    bit any, exp_fv, hit;
    logic [NR-1:0] exp_rr, exp_rv;
    logic exp_frr;
    g = 0; any = 1'b0;
    if (m_lock) begin
      g   = m_lock_idx;
      any = req_valid_i[g];
    end else begin
      for (int i = 0; i < NR; i++) begin
        c = (m_rr + i) % NR;
        if (!any && req_valid_i[c]) begin
          any = 1'b1;
          g   = c;
        end
      end
    end
    s = -1; cnt = 0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (!m_valid[i]) s = i;
      if (m_valid[i]) cnt++;
    end
    exp_fv = any && (s >= 0) && !flush_i;
    chk("fpu_valid", 32'(fpu_valid_o), 32'(exp_fv));
    if (exp_fv) begin
      chk("fpu_tag", 32'(fpu_tag_o), s);
      chk("fpu_payload", 32'(fpu_payload_o), 32'(r_pay[g]));
    end
    exp_rr = (exp_fv && fpu_ready_i) ? NR'(1 << g) : '0;
    chk("req_ready", 32'(req_ready_o), 32'(exp_rr));

    t   = int'(fpu_rsp_tag_i);
    hit = m_valid[t];
    o   = m_owner[t];
    exp_rv  = (fpu_rsp_valid_i && hit && !flush_i) ? NR'(1 << o) : '0;
    exp_frr = hit ? rsp_ready_i[o] : 1'b1;
    chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rv));
    chk("fpu_rsp_ready", 32'(fpu_rsp_ready_o), 32'(exp_frr));
    chk("inflight", 32'(inflight_o), cnt);
    chk("busy", 32'(busy_o), 32'(cnt != 0));

    if (flush_i) begin
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
      m_lock = 1'b0;
      fq.delete();
      sb.delete();
      h_act = 1'b0;
    end else begin
      if (fpu_rsp_valid_i && hit && rsp_ready_i[o]) begin
        m_valid[t] = 1'b0;
        for (int i = fq.size() - 1; i >= 0; i--) if (fq[i].slot == t) fq.delete(i);
        h_act = 1'b0;
      end
      if (exp_fv && fpu_ready_i) begin
        m_valid[s] = 1'b1;
        m_owner[s] = g;
        m_rr       = (g + 1) % NR;
        m_lock     = 1'b0;
        sb.push_back('{req: g, tag: r_tag[g], res: fpu_op(r_pay[g])});
        fq.push_back('{slot: s, res: fpu_op(fpu_payload_o)});
        r_act[g] = 1'b0;
      end else if (exp_fv) begin
        m_lock     = 1'b1;
        m_lock_idx = g;
      end
    end
  endtask

  // Monitor: every delivered response must match an outstanding request.
  initial begin : monitor
    int k;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int r = 0; r < NR; r++) begin
          if (rsp_valid_o[r] && rsp_ready_i[r]) begin
            k = -1;
            foreach (sb[i]) if (k < 0 && sb[i].req == r && sb[i].tag == rsp_tag_o) k = i;
            if (k < 0) begin
              n_vec++;
              n_err++;
              $display("FAIL rsp_route: requester %0d got tag %0h, required an outstanding tag of that requester",
                       r, rsp_tag_o);
            end else begin
              chk("rsp_payload", 32'(rsp_payload_o), 32'(sb[k].res));
              sb.delete(k);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    for (int r = 0; r < NR; r++) begin
      r_act[r]   = 1'b0;
      tag_cnt[r] = 8'(r * 64);
      r_tag[r]   = '0;
      r_pay[r]   = '0;
    end
    for (int i = 0; i < NS; i++) m_owner[i] = 0;
    m_lock_idx = 0;
    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_fpu_valid", 32'(fpu_valid_o), 0);
    chk("rst_req_ready", 32'(req_ready_o), 0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_inflight", 32'(inflight_o), 0);
    chk("rst_fpu_rsp_ready", 32'(fpu_rsp_ready_o), 1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1500 || cyc == 1501) begin
        rst = 1'b1;
        drive_idle();
      end else begin
        rst = 1'b0;
        drive(cyc);
      end
      @(negedge clk);
      if (rst) model_reset();
      else check_and_update();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
